// File: rtl/idct_serial8.sv
// Serial 8-point inverse DCT: accepts one block of eight coefficients, then
// produces the eight reconstructed samples one at a time through a
// valid/ready handshake. A single multiplier is reused for every term.
module idct_serial8 #(
  parameter int OUT_SHIFT = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic signed [18:0] coef0,
  input  logic signed [18:0] coef1,
  input  logic signed [18:0] coef2,
  input  logic signed [18:0] coef3,
  input  logic signed [18:0] coef4,
  input  logic signed [18:0] coef5,
  input  logic signed [18:0] coef6,
  input  logic signed [18:0] coef7,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [7:0]  out_sample,
  output logic [2:0]         out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t             state_q, state_d;
  logic [2:0]         n_q;        // sample index being produced
  logic [3:0]         step_q;     // 0: ROM read, 1..8: accumulate k=step-1, 9: round/saturate
  logic signed [37:0] acc_q;
  logic signed [15:0] rom_q;
  logic signed [18:0] coef_q [8];
  logic signed [7:0]  out_sample_q;
  logic [2:0]         out_idx_q;
  logic               out_last_q;

  logic               in_xfer, out_xfer;
  logic [2:0]         k_idx;
  logic signed [18:0] coef_sel;
  logic signed [34:0] prod;
  logic signed [37:0] rnd, shr;
  logic signed [7:0]  sat_val;

  // Basis value C[k][n] = round(16384*a_k*cos((2n+1)k*pi/16)). The angle is
  // folded into the first quadrant so only nine magnitudes are needed.
  function automatic logic signed [15:0] rom_coef(input logic [2:0] k, input logic [2:0] n);
    logic [4:0]         m;
    logic [4:0]         r;
    logic               neg;
    logic signed [15:0] mag;
    m = {1'b0, n, 1'b1} * {2'b00, k};   // (2n+1)k mod 32, in units of pi/16
    if (m > 5'd16) m = 5'd0 - m;        // cos(2pi - x) = cos(x)
    neg = (m > 5'd8);                   // second quadrant is negative
    r   = neg ? (5'd16 - m) : m;
    case (r)
      5'd0:    mag = 16'sd8192;
      5'd1:    mag = 16'sd8035;
      5'd2:    mag = 16'sd7568;
      5'd3:    mag = 16'sd6811;
      5'd4:    mag = 16'sd5793;
      5'd5:    mag = 16'sd4551;
      5'd6:    mag = 16'sd3135;
      5'd7:    mag = 16'sd1598;
      default: mag = 16'sd0;
    endcase
    if (k == 3'd0) mag = 16'sd5793;     // DC row uses 1/sqrt(8) scaling
    return neg ? -mag : mag;
  endfunction

  assign in_xfer  = en & in_valid & in_ready;
  assign out_xfer = en & out_valid & out_ready;

  assign k_idx    = 3'(step_q - 4'd1);
  assign coef_sel = coef_q[k_idx];
  assign prod     = coef_sel * rom_q;

  assign rnd = acc_q + (38'sd1 <<< (OUT_SHIFT - 1));
  assign shr = rnd >>> OUT_SHIFT;

  // Clamp the scaled accumulator into the signed 8-bit output range
  always_comb begin
    sat_val = shr[7:0];
    if (shr > 38'sd127)       sat_val = 8'sd127;
    else if (shr < -38'sd128) sat_val = -8'sd128;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  state_q <= IDLE;
    else if (en) state_q <= state_d;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = MAC;
      end
      MAC: begin
        if (step_q == 4'd9) state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = (n_q == 3'd7) ? IDLE : MAC;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: coefficient capture, ROM read, multiply-accumulate, output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q          <= '0;
      step_q       <= '0;
      acc_q        <= '0;
      rom_q        <= '0;
      out_sample_q <= '0;
      out_idx_q    <= '0;
      out_last_q   <= 1'b0;
      for (int i = 0; i < 8; i++) coef_q[i] <= '0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if (in_xfer) begin
            coef_q[0] <= coef0;
            coef_q[1] <= coef1;
            coef_q[2] <= coef2;
            coef_q[3] <= coef3;
            coef_q[4] <= coef4;
            coef_q[5] <= coef5;
            coef_q[6] <= coef6;
            coef_q[7] <= coef7;
            n_q       <= '0;
            step_q    <= '0;
            acc_q     <= '0;
          end
        end
        MAC: begin
          if (step_q < 4'd8) rom_q <= rom_coef(step_q[2:0], n_q);
          if (step_q >= 4'd1 && step_q <= 4'd8) acc_q <= acc_q + 38'(prod);
          if (step_q == 4'd9) begin
            out_sample_q <= sat_val;
            out_idx_q    <= n_q;
            out_last_q   <= (n_q == 3'd7);
            step_q       <= '0;
          end else begin
            step_q <= step_q + 4'd1;
          end
        end
        OUT: begin
          if (out_xfer) begin
            if (n_q != 3'd7) n_q <= n_q + 3'd1;
            acc_q  <= '0;
            step_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sample = out_sample_q;
  assign out_idx    = out_idx_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_idct_serial8.sv
// Directed bench for idct_serial8: known blocks with hand-computed samples,
// backpressure, clock-enable stalls, latency and mid-block reset.
module tb_idct_serial8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [18:0] coef_d [8];
  logic in_ready, out_valid, out_last;
  logic signed [7:0] out_sample;
  logic [2:0] out_idx;

  logic signed [18:0] blk [8];
  int exp_s [8];
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  idct_serial8 #(.OUT_SHIFT(14)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .coef0      (coef_d[0]),
    .coef1      (coef_d[1]),
    .coef2      (coef_d[2]),
    .coef3      (coef_d[3]),
    .coef4      (coef_d[4]),
    .coef5      (coef_d[5]),
    .coef6      (coef_d[6]),
    .coef7      (coef_d[7]),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_sample (out_sample),
    .out_idx    (out_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
    end
  endtask

  // Send blk, then collect and check eight samples. stall!=0 drops en for
  // three cycles during sample 0's MAC; bp_idx holds out_ready low for five
  // cycles on that sample; rst_after resets the design after that sample.
  task automatic run_block(input string name, input int stall, input int bp_idx, input int rst_after);
    int cnt;
    int bad;
    int seen;
    logic signed [7:0] held;
    for (int k = 0; k < 8; k++) coef_d[k] = blk[k];
    in_valid = 1'b1;
    chk($sformatf("%s/in_ready_idle", name), in_ready, 1);
    @(posedge clk); #1;
    // keep presenting a different block; it must be ignored
    for (int k = 0; k < 8; k++) coef_d[k] = 19'(k * 1000 - 3000);
    for (int i = 0; i < 8; i++) begin
      cnt = 0;
      while (!out_valid && cnt < 40) begin
        en = !(stall != 0 && i == 0 && (cnt == 2 || cnt == 4 || cnt == 6));
        @(posedge clk); #1;
        cnt++;
      end
      en = 1'b1;
      chk($sformatf("%s/lat%0d", name, i), cnt, (stall != 0 && i == 0) ? 13 : 10);
      chk($sformatf("%s/sample%0d", name, i), out_sample, exp_s[i]);
      chk($sformatf("%s/idx%0d", name, i), out_idx, i);
      chk($sformatf("%s/last%0d", name, i), out_last, (i == 7) ? 1 : 0);
      chk($sformatf("%s/in_ready_busy%0d", name, i), in_ready, 0);
      $display("[TB] %s n=%0d sample=%0d last=%0d latency=%0d", name, out_idx, out_sample, out_last, cnt);
      if (i == bp_idx) begin
        out_ready = 1'b0;
        held = out_sample;
        bad = 0;
        repeat (5) begin
          @(posedge clk); #1;
          if (out_valid !== 1'b1 || out_sample !== held || out_idx !== 3'(i) || in_ready !== 1'b0) bad++;
        end
        chk($sformatf("%s/backpressure_hold", name), bad, 0);
        out_ready = 1'b1;
      end
      if (i == 7) in_valid = 1'b0;
      @(posedge clk); #1;   // output transfer edge
      chk($sformatf("%s/valid_drop%0d", name, i), out_valid, 0);
      if (i == 7) chk($sformatf("%s/in_ready_after_last", name), in_ready, 1);
      if (i == rst_after) begin
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk($sformatf("%s/rst_in_ready", name), in_ready, 1);
        chk($sformatf("%s/rst_out_valid", name), out_valid, 0);
        chk($sformatf("%s/rst_out_sample", name), out_sample, 0);
        chk($sformatf("%s/rst_out_idx", name), out_idx, 0);
        chk($sformatf("%s/rst_out_last", name), out_last, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
          @(posedge clk); #1;
          if (out_valid) seen++;
        end
        chk($sformatf("%s/no_output_after_reset", name), seen, 0);
        $display("[TB] %s reset after sample %0d, block discarded", name, i);
        return;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) coef_d[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/in_ready", in_ready, 1);
    chk("reset/out_valid", out_valid, 0);
    chk("reset/out_sample", out_sample, 0);
    chk("reset/out_idx", out_idx, 0);
    chk("reset/out_last", out_last, 0);
    rst_n = 1'b1;

    blk = '{19'sd200, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0};
    exp_s = '{71, 71, 71, 71, 71, 71, 71, 71};
    run_block("dc200", 0, -1, -1);

    blk = '{19'sd800, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0};
    exp_s = '{127, 127, 127, 127, 127, 127, 127, 127};
    run_block("sat_pos", 0, -1, -1);

    blk = '{-19'sd800, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0};
    exp_s = '{-128, -128, -128, -128, -128, -128, -128, -128};
    run_block("sat_neg", 0, -1, -1);

    blk = '{19'sd0, 19'sd100, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0};
    exp_s = '{49, 42, 28, 10, -10, -28, -42, -49};
    run_block("ac1", 0, -1, -1);

    blk = '{19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0};
    exp_s = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_block("zero", 0, -1, -1);

    blk = '{19'sd200, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0};
    exp_s = '{71, 71, 71, 71, 71, 71, 71, 71};
    run_block("dc_bp", 0, 3, -1);

    blk = '{19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd100};
    exp_s = '{10, -28, 42, -49, 49, -42, 28, -10};
    run_block("ac7_stall", 1, -1, -1);

    blk = '{19'sd200, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0};
    exp_s = '{71, 71, 71, 71, 71, 71, 71, 71};
    run_block("dc_rst", 0, -1, 2);

    blk = '{19'sd200, 19'sd0, 19'sd100, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0};
    exp_s = '{117, 90, 52, 25, 25, 52, 90, 117};
    run_block("mix_after_rst", 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
